// File: rtl/uart_receiver.sv
// 8E1 UART receiver driven by a 16x oversampling strobe; samples each bit at mid-period
// and reports bytes with a one-cycle valid pulse plus sticky parity/framing error flags.
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_ENABLE,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          r_state;
    logic            r_rxd_meta;
    logic            r_rxd_s;
    logic [TW-1:0]   r_tick;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_perr;
    logic            r_ferr;

    state_t          w_state_next;
    logic [TW-1:0]   w_tick_next;
    logic [2:0]      w_bit_next;
    logic [7:0]      w_shift_next;
    logic [7:0]      w_data_next;
    logic            w_valid_next;
    logic            w_perr_next;
    logic            w_ferr_next;
    logic            w_tick_mid;
    logic            w_tick_done;

    assign w_tick_mid  = sample_ENABLE && (r_tick == TICK_MID);
    assign w_tick_done = sample_ENABLE && (r_tick == TICK_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
            r_state    <= S_IDLE;
            r_tick     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_rxd_meta <= RxD;
            r_rxd_s    <= r_rxd_meta;
            r_state    <= w_state_next;
            r_tick     <= w_tick_next;
            r_bit      <= w_bit_next;
            r_shift    <= w_shift_next;
            r_data     <= w_data_next;
            r_valid    <= w_valid_next;
            r_perr     <= w_perr_next;
            r_ferr     <= w_ferr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tick_next  = r_tick;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_data_next  = r_data;
        w_valid_next = 1'b0;
        w_perr_next  = r_perr;
        w_ferr_next  = r_ferr;

        if (!Rx_EN) begin
            w_state_next = S_IDLE;
        end else begin
            // The tick counter free-runs modulo OVERSAMPLE once a frame is under way.
            if (sample_ENABLE && (r_state != S_IDLE)) begin
                w_tick_next = r_tick + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (!r_rxd_s) begin
                        w_tick_next  = '0;
                        w_bit_next   = '0;
                        w_perr_next  = 1'b0;
                        w_ferr_next  = 1'b0;
                        w_state_next = S_START;
                    end
                end
                S_START: begin
                    if (w_tick_mid) begin
                        if (!r_rxd_s) begin
                            w_tick_next  = '0;
                            w_state_next = S_DATA;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick_done) begin
                        w_shift_next = {r_rxd_s, r_shift[7:1]};
                        w_bit_next   = r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            w_state_next = S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick_done) begin
                        w_perr_next  = r_perr | (^{r_shift, r_rxd_s});
                        w_state_next = S_STOP;
                    end
                end
                S_STOP: begin
                    // Leaving at mid-stop-bit lets a back-to-back start edge be caught next cycle.
                    if (w_tick_done) begin
                        w_ferr_next  = r_ferr | ~r_rxd_s;
                        w_data_next  = r_shift;
                        w_valid_next = ~r_perr & r_rxd_s;
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign Rx_DATA   = r_data;
    assign Rx_VALID  = r_valid;
    assign Rx_PERROR = r_perr;
    assign Rx_FERROR = r_ferr;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: table of whole frames plus hand-written corner sequences,
// with a scoreboard checking every Rx_VALID pulse for data and start-to-valid latency.
module tb_uart_receiver;

    localparam int BIT_CLK    = 432;
    localparam int STROBE_CLK = 27;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_ENABLE = 1'b0;
    logic       Rx_EN = 1'b0;
    logic       RxD = 1'b1;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    uart_receiver #(.OVERSAMPLE(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_ENABLE (sample_ENABLE),
        .Rx_EN         (Rx_EN),
        .RxD           (RxD),
        .Rx_DATA       (Rx_DATA),
        .Rx_VALID      (Rx_VALID),
        .Rx_PERROR     (Rx_PERROR),
        .Rx_FERROR     (Rx_FERROR)
    );

    always #10 clk = ~clk;

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_strobes = 0;
    int   valid_cnt = 0;
    logic seen_perr = 1'b0;
    logic seen_ferr = 1'b0;
    logic prev_valid = 1'b0;

    typedef struct {
        logic [7:0] data;
        int         start_strobe;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_valid;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe generator: one sample_ENABLE every 27 clocks, counted as it is raised.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (cnt == STROBE_CLK - 1) begin
                cnt = 0;
                sample_ENABLE = 1'b1;
                n_strobes++;
            end else begin
                cnt++;
                sample_ENABLE = 1'b0;
            end
        end
    end

    // Output monitor and scoreboard consumer.
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (Rx_PERROR) seen_perr = 1'b1;
            if (Rx_FERROR) seen_ferr = 1'b1;
            if (Rx_VALID) begin
                valid_cnt++;
                check("valid_pulse_width", prev_valid, 0);
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e   = sb_q.pop_front();
                    lat = n_strobes - e.start_strobe;
                    $display("rx byte 0x%02h expected 0x%02h latency %0d strobes", Rx_DATA, e.data, lat);
                    check("sb_data", Rx_DATA, e.data);
                    check("sb_latency_168", (lat == 168 || lat == 169), 1);
                end
            end
            prev_valid = Rx_VALID;
        end
    end

    // Drives one frame from a negedge; a 0 stop bit is held only past its mid-point.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input logic exp_valid, input int gap_bits);
        logic [9:0] bits;
        bits = {par, d, 1'b0};
        if (exp_valid) sb_q.push_back('{d, n_strobes});
        RxD = 1'b0;
        clocks(10);
        valid_cnt = 0;
        seen_perr = 1'b0;
        seen_ferr = 1'b0;
        clocks(BIT_CLK - 10);
        for (int i = 1; i < 10; i++) begin
            RxD = bits[i];
            clocks(BIT_CLK);
        end
        if (stop) begin
            RxD = 1'b1;
            clocks(BIT_CLK);
        end else begin
            RxD = 1'b0;
            clocks(10 * STROBE_CLK);
            RxD = 1'b1;
            clocks(BIT_CLK - 10 * STROBE_CLK);
        end
        RxD = 1'b1;
        clocks(gap_bits * BIT_CLK);
    endtask

    initial begin
        logic [7:0] d;

        vecs[0] = '{8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hA7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h96, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        clocks(3);
        check("reset_data",  Rx_DATA,   8'h00);
        check("reset_valid", Rx_VALID,  0);
        check("reset_perr",  Rx_PERROR, 0);
        check("reset_ferr",  Rx_FERROR, 0);
        reset = 1'b1;
        Rx_EN = 1'b1;
        clocks(BIT_CLK);

        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].exp_valid, 1);
            $display("frame %0d data 0x%02h: valid %0d perr %0d ferr %0d rx_data 0x%02h",
                     i, vecs[i].data, valid_cnt, seen_perr, seen_ferr, Rx_DATA);
            check("tbl_valid_count", valid_cnt, vecs[i].exp_valid);
            check("tbl_perr_seen",   seen_perr, vecs[i].exp_perr);
            check("tbl_ferr_seen",   seen_ferr, vecs[i].exp_ferr);
            check("tbl_data",        Rx_DATA,   vecs[i].data);
            check("tbl_perr_sticky", Rx_PERROR, vecs[i].exp_perr);
        end

        valid_cnt = 0;
        seen_perr = 1'b0;
        seen_ferr = 1'b0;
        RxD = 1'b0;
        clocks(4 * STROBE_CLK);
        RxD = 1'b1;
        clocks(2 * BIT_CLK);
        $display("false start: valid %0d perr %0d ferr %0d rx_data 0x%02h", valid_cnt, seen_perr, seen_ferr, Rx_DATA);
        check("fs_valid", valid_cnt, 0);
        check("fs_data",  Rx_DATA, 8'h01);
        check("fs_flags", {seen_perr, seen_ferr}, 0);
        send_frame(8'h81, 1'b0, 1'b1, 1'b1, 1);
        $display("after false start: valid %0d rx_data 0x%02h", valid_cnt, Rx_DATA);
        check("fs_next_valid", valid_cnt, 1);
        check("fs_next_data",  Rx_DATA, 8'h81);

        send_frame(8'h00, 1'b0, 1'b1, 1'b1, 0);
        $display("b2b first: valid %0d rx_data 0x%02h", valid_cnt, Rx_DATA);
        check("b2b_first_valid", valid_cnt, 1);
        check("b2b_first_data",  Rx_DATA, 8'h00);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 1);
        $display("b2b second: valid %0d rx_data 0x%02h", valid_cnt, Rx_DATA);
        check("b2b_second_valid", valid_cnt, 1);
        check("b2b_second_data",  Rx_DATA, 8'hFF);

        d = 8'h5A;
        valid_cnt = 0;
        RxD = 1'b0;
        clocks(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            RxD = d[i];
            clocks(BIT_CLK);
        end
        Rx_EN = 1'b0;
        for (int i = 4; i < 8; i++) begin
            RxD = d[i];
            clocks(BIT_CLK);
        end
        RxD = 1'b0;
        clocks(BIT_CLK);
        RxD = 1'b1;
        clocks(2 * BIT_CLK);
        Rx_EN = 1'b1;
        clocks(BIT_CLK);
        $display("rx_en abort: valid %0d rx_data 0x%02h", valid_cnt, Rx_DATA);
        check("abort_valid", valid_cnt, 0);
        check("abort_data",  Rx_DATA, 8'hFF);

        d = 8'h0F;
        valid_cnt = 0;
        RxD = 1'b0;
        clocks(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            RxD = d[i];
            clocks(BIT_CLK);
        end
        RxD = d[4];
        clocks(BIT_CLK / 2);
        #3 reset = 1'b0;
        #1;
        $display("mid-frame reset: rx_data 0x%02h valid %0d perr %0d ferr %0d", Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR);
        check("rst_mid_data",  Rx_DATA,   8'h00);
        check("rst_mid_valid", Rx_VALID,  0);
        check("rst_mid_perr",  Rx_PERROR, 0);
        check("rst_mid_ferr",  Rx_FERROR, 0);
        RxD = 1'b1;
        clocks(3);
        reset = 1'b1;
        clocks(2 * BIT_CLK);
        send_frame(8'h42, 1'b0, 1'b1, 1'b1, 1);
        $display("after reset: valid %0d rx_data 0x%02h", valid_cnt, Rx_DATA);
        check("post_rst_valid", valid_cnt, 1);
        check("post_rst_data",  Rx_DATA, 8'h42);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
